// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter: default geometry, the
// left/right sample-pair type and the word-select decode.
package i2s_pkg;

    // Default link geometry: 24-bit samples in 32-bit slots, BCK = AMCLK/4.
    localparam int I2S_SAMPLE_WIDTH     = 24;
    localparam int I2S_SLOT_WIDTH       = 32;
    localparam int I2S_MCLK_DIV         = 4;

    // Widest sample the pair container can carry.  Narrower samples are
    // stored LSB-aligned and the upper bits stay zero.
    localparam int I2S_MAX_SAMPLE_WIDTH = 32;

    typedef struct packed {
        logic [I2S_MAX_SAMPLE_WIDTH-1:0] left;
        logic [I2S_MAX_SAMPLE_WIDTH-1:0] right;
    } i2s_pair_t;

    // Word select for the bit that is being launched.  The one-BCK I2S delay
    // means WS goes high on the last bit of the left slot and drops on the
    // last bit of the right slot, one BCK ahead of each channel's MSB.
    function automatic logic i2s_ws(input int bit_idx, input int slot_width);
        return (bit_idx >= slot_width - 1) && (bit_idx <= 2 * slot_width - 2);
    endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: divides AMCLK by MCLK_DIV into a 50% duty BCK and
// provides single-cycle strobes for the cycles that produce each BCK edge.
module i2s_bck_gen
    import i2s_pkg::*;
#(
    parameter int MCLK_DIV = I2S_MCLK_DIV
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic bck_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int DIV_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(MCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             bck_q;
    logic             bck_d;

    // Strobes mark the AMCLK cycle whose closing edge moves BCK.
    assign rise_tick_o = (div_cnt_q == DIV_RISE);
    assign fall_tick_o = (div_cnt_q == DIV_LAST);
    assign bck_o       = bck_q;

    // Divider wraps at MCLK_DIV-1; BCK rises halfway and falls on the wrap.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        bck_d     = bck_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
        if (rise_tick_o) begin
            bck_d = 1'b1;
        end else if (fall_tick_o) begin
            bck_d = 1'b0;
        end
    end

    // Divider and BCK state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= '0;
            bck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bck_q     <= bck_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S bus-master transmitter.  A stereo pair is taken over a
// valid/ready handshake into a one-deep holding register and moved into the
// frame shift register at the start of every frame; an empty holding
// register at that moment yields a silent frame and an underrun pulse.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
    parameter int MCLK_DIV     = I2S_MCLK_DIV
) (
    input  logic                    AMCLK_i,
    input  logic                    nARST,
    input  logic [SAMPLE_WIDTH-1:0] sample_l_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_r_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    output logic                    ASCLK_o,
    output logic                    ALRCLK_o,
    output logic                    ASDATA_o,
    output logic                    frame_start_o,
    output logic                    underrun_o
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    // Bit clock and its edge strobes.
    logic fall_tick;
    logic unused_bck_rise;

    // Frame position and serial output state.
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_d;
    logic                  ws_q;
    logic                  ws_d;
    logic                  sdata_q;
    logic                  sdata_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;

    // Holding register and handshake.
    i2s_pair_t             hold_q;
    i2s_pair_t             hold_d;
    logic                  hold_full_q;
    logic                  hold_full_d;
    logic                  ready_q;
    logic                  ready_d;

    // Status pulses.
    logic                  frame_start_q;
    logic                  frame_start_d;
    logic                  underrun_q;
    logic                  underrun_d;

    // Combinational helpers.
    i2s_pair_t             in_pair;
    logic [FRAME_BITS-1:0] frame_vec;
    logic                  load;
    logic                  accept;
    logic                  unused_hold_bits;

    i2s_bck_gen #(
        .MCLK_DIV (MCLK_DIV)
    ) u_bck_gen (
        .clk_i       (AMCLK_i),
        .rst_n_i     (nARST),
        .bck_o       (ASCLK_o),
        .rise_tick_o (unused_bck_rise),
        .fall_tick_o (fall_tick)
    );

    // The frame is reloaded on the fall tick that wraps the bit counter to 0.
    assign load   = fall_tick && (bit_cnt_q == CNT_LAST);
    // Ready is registered, so a pair offered during the load cycle of a full
    // holding register is simply not taken; it goes in one cycle later.
    assign accept = sample_valid_i && ready_q;

    // Holding-register bits above SAMPLE_WIDTH are always zero and never read.
    assign unused_hold_bits = ^{hold_q.left, hold_q.right};

    // Widen the incoming samples into the pair container.
    always_comb begin
        in_pair = '0;
        in_pair.left[SAMPLE_WIDTH-1:0]  = sample_l_i;
        in_pair.right[SAMPLE_WIDTH-1:0] = sample_r_i;
    end

    // Lay out the full frame MSB first: left slot, then right slot, each
    // sample left-justified with zero padding.  Empty holding gives silence.
    always_comb begin
        frame_vec = '0;
        if (hold_full_q) begin
            frame_vec[FRAME_BITS-1 -: SAMPLE_WIDTH] = hold_q.left[SAMPLE_WIDTH-1:0];
            frame_vec[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = hold_q.right[SAMPLE_WIDTH-1:0];
        end
    end

    // Next-state logic for counter, serializer, holding register and pulses.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        ws_d          = ws_q;
        sdata_d       = sdata_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (fall_tick) begin
            if (bit_cnt_q == CNT_LAST) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            ws_d = i2s_ws(int'(bit_cnt_d), SLOT_WIDTH);

            if (load) begin
                // Launch bit 0 of the new frame straight from the layout and
                // keep the rest queued in the shift register.
                sdata_d       = frame_vec[FRAME_BITS-1];
                shift_d       = {frame_vec[FRAME_BITS-2:0], 1'b0};
                frame_start_d = 1'b1;
                underrun_d    = !hold_full_q;
                hold_full_d   = 1'b0;
            end else begin
                sdata_d = shift_q[FRAME_BITS-1];
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end

        // Accept is only possible when the holding register is already empty,
        // so it can never clobber a pair that is still waiting to be sent.
        if (accept) begin
            hold_d      = in_pair;
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d;
    end

    // State registers; reset abandons the current frame and any held pair.
    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            bit_cnt_q     <= CNT_LAST;
            ws_q          <= 1'b0;
            sdata_q       <= 1'b0;
            shift_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            ws_q          <= ws_d;
            sdata_q       <= sdata_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign ALRCLK_o       = ws_q;
    assign ASDATA_o       = sdata_q;
    assign sample_ready_o = ready_q;
    assign frame_start_o  = frame_start_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed testbench for i2s_tx at the default geometry
// (24-bit samples, 32-bit slots, 4 AMCLK per BCK, 256 AMCLK per frame).
`timescale 1ns/1ps
module tb_i2s_tx;

    localparam int SW        = 24;
    localparam int SLOT      = 32;
    localparam int DIV       = 4;
    localparam int FRAME_CYC = 2 * SLOT * DIV;
    localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

    logic          AMCLK_i        = 1'b0;
    logic          nARST          = 1'b0;
    logic [SW-1:0] sample_l_i     = '0;
    logic [SW-1:0] sample_r_i     = '0;
    logic          sample_valid_i = 1'b0;
    logic          sample_ready_o;
    logic          ASCLK_o;
    logic          ALRCLK_o;
    logic          ASDATA_o;
    logic          frame_start_o;
    logic          underrun_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit cap_done = 1'b0;

    always #5 AMCLK_i = ~AMCLK_i;

    i2s_tx #(
        .SAMPLE_WIDTH (SW),
        .SLOT_WIDTH   (SLOT),
        .MCLK_DIV     (DIV)
    ) dut (
        .AMCLK_i        (AMCLK_i),
        .nARST          (nARST),
        .sample_l_i     (sample_l_i),
        .sample_r_i     (sample_r_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .ASCLK_o        (ASCLK_o),
        .ALRCLK_o       (ALRCLK_o),
        .ASDATA_o       (ASDATA_o),
        .frame_start_o  (frame_start_o),
        .underrun_o     (underrun_o)
    );

    // Expected serial frame: left slot then right slot, 8 zero pad bits each.
    function automatic logic [63:0] frame_of(input logic [SW-1:0] l, input logic [SW-1:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge AMCLK_i);
            if (frame_start_o) ok = 1'b1;
        end
    endtask

    // Offer a pair and hold valid until the DUT takes it.
    task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r, output bit ok);
        bit rdy;
        ok = 1'b0;
        sample_l_i     = l;
        sample_r_i     = r;
        sample_valid_i = 1'b1;
        for (int i = 0; i < 600 && !ok; i++) begin
            rdy = sample_ready_o;
            @(negedge AMCLK_i);
            if (rdy) ok = 1'b1;
        end
        sample_valid_i = 1'b0;
    endtask

    // Receiver: wait for a frame start, then sample data and WS on 64 BCK rises.
    task automatic capture_frame(output logic [63:0] data, output logic [63:0] ws,
                                 output logic ur, output bit ok);
        bit   seen;
        logic prev;
        int   n;
        data = '0;
        ws   = '0;
        ur   = 1'b0;
        ok   = 1'b0;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge AMCLK_i);
            if (frame_start_o) begin
                seen = 1'b1;
                ur   = underrun_o;
            end
        end
        if (seen) begin
            prev = ASCLK_o;
            for (int i = 0; i < 400 && n < 64; i++) begin
                @(negedge AMCLK_i);
                if (ASCLK_o && !prev) begin
                    data[63-n] = ASDATA_o;
                    ws[63-n]   = ALRCLK_o;
                    n++;
                end
                prev = ASCLK_o;
            end
            ok = (n == 64);
        end
    endtask

    task automatic test_reset();
        int lat;
        nARST          = 1'b0;
        sample_valid_i = 1'b0;
        repeat (3) @(negedge AMCLK_i);
        vec_cnt++; if (ASCLK_o !== 1'b0) begin err_cnt++; $display("FAIL reset_asclk: got %b expected 0", ASCLK_o); end
        vec_cnt++; if (ALRCLK_o !== 1'b0) begin err_cnt++; $display("FAIL reset_ws: got %b expected 0", ALRCLK_o); end
        vec_cnt++; if (ASDATA_o !== 1'b0) begin err_cnt++; $display("FAIL reset_data: got %b expected 0", ASDATA_o); end
        vec_cnt++; if (sample_ready_o !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b expected 1", sample_ready_o); end
        vec_cnt++; if (frame_start_o !== 1'b0) begin err_cnt++; $display("FAIL reset_fs: got %b expected 0", frame_start_o); end
        vec_cnt++; if (underrun_o !== 1'b0) begin err_cnt++; $display("FAIL reset_ur: got %b expected 0", underrun_o); end
        nARST = 1'b1;
        lat = 0;
        for (int i = 1; i <= 16 && lat == 0; i++) begin
            @(negedge AMCLK_i);
            if (frame_start_o) lat = i;
        end
        vec_cnt++; if (lat != DIV) begin err_cnt++; $display("FAIL reset_latency: got %0d expected %0d", lat, DIV); end
        $display("[reset] first frame start %0d cycles after release", lat);
    endtask

    // Idle link: check every AMCLK cycle of two whole frames.
    task automatic test_idle();
        int   ph;
        int   k;
        logic exp_bck;
        logic exp_ws;
        logic exp_fs;
        for (int j = 0; j < 2 * FRAME_CYC; j++) begin
            if (j > 0) @(negedge AMCLK_i);
            ph      = j % DIV;
            k       = (j / DIV) % (2 * SLOT);
            exp_bck = (ph >= DIV / 2);
            exp_ws  = (k >= SLOT - 1) && (k <= 2 * SLOT - 2);
            exp_fs  = ((j % FRAME_CYC) == 0);
            vec_cnt++; if (ASCLK_o !== exp_bck) begin err_cnt++; $display("FAIL idle_asclk@%0d: got %b expected %b", j, ASCLK_o, exp_bck); end
            vec_cnt++; if (ALRCLK_o !== exp_ws) begin err_cnt++; $display("FAIL idle_ws@%0d: got %b expected %b", j, ALRCLK_o, exp_ws); end
            vec_cnt++; if (ASDATA_o !== 1'b0) begin err_cnt++; $display("FAIL idle_data@%0d: got %b expected 0", j, ASDATA_o); end
            vec_cnt++; if (frame_start_o !== exp_fs) begin err_cnt++; $display("FAIL idle_fs@%0d: got %b expected %b", j, frame_start_o, exp_fs); end
            vec_cnt++; if (underrun_o !== exp_fs) begin err_cnt++; $display("FAIL idle_ur@%0d: got %b expected %b", j, underrun_o, exp_fs); end
            vec_cnt++; if (sample_ready_o !== 1'b1) begin err_cnt++; $display("FAIL idle_ready@%0d: got %b expected 1", j, sample_ready_o); end
        end
        $display("[idle] two silent frames checked cycle by cycle");
    endtask

    task automatic test_pattern();
        bit          ok;
        logic [63:0] data;
        logic [63:0] ws;
        logic        ur;
        wait_frame_start(ok);
        repeat (8) @(negedge AMCLK_i);
        push_pair(24'hA5A5A5, 24'h5A5A5A, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL pattern_accept: got timeout expected accept"); end
        vec_cnt++; if (sample_ready_o !== 1'b0) begin err_cnt++; $display("FAIL pattern_ready_after: got %b expected 0", sample_ready_o); end
        capture_frame(data, ws, ur, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL pattern_capture: got timeout expected frame"); end
        vec_cnt++; if (data !== frame_of(24'hA5A5A5, 24'h5A5A5A)) begin err_cnt++; $display("FAIL pattern_data: got %h expected %h", data, frame_of(24'hA5A5A5, 24'h5A5A5A)); end
        vec_cnt++; if (ws !== WS_EXP) begin err_cnt++; $display("FAIL pattern_ws: got %h expected %h", ws, WS_EXP); end
        vec_cnt++; if (ur !== 1'b0) begin err_cnt++; $display("FAIL pattern_ur: got %b expected 0", ur); end
        $display("[pattern] frame %h ws %h", data, ws);
        capture_frame(data, ws, ur, ok);
        vec_cnt++; if (ur !== 1'b1) begin err_cnt++; $display("FAIL pattern_next_ur: got %b expected 1", ur); end
        vec_cnt++; if (data !== 64'h0) begin err_cnt++; $display("FAIL pattern_next_data: got %h expected 0", data); end
        $display("[pattern] following frame silent, underrun %b", ur);
    endtask

    task automatic test_full_scale();
        bit          ok;
        logic [63:0] data;
        logic [63:0] ws;
        logic        ur;
        wait_frame_start(ok);
        repeat (8) @(negedge AMCLK_i);
        push_pair(24'h800000, 24'h7FFFFF, ok);
        capture_frame(data, ws, ur, ok);
        vec_cnt++; if (data !== frame_of(24'h800000, 24'h7FFFFF)) begin err_cnt++; $display("FAIL fullscale_data: got %h expected %h", data, frame_of(24'h800000, 24'h7FFFFF)); end
        vec_cnt++; if (ur !== 1'b0) begin err_cnt++; $display("FAIL fullscale_ur: got %b expected 0", ur); end
        $display("[fullscale] frame %h", data);
    endtask

    // Continuous valid with an incrementing pattern across three frames.
    task automatic test_back_to_back();
        bit          ok;
        bit          rdy;
        int          n;
        int          acc_at [0:7];
        logic [63:0] data;
        logic [63:0] ws;
        logic        ur;
        logic [SW-1:0] el;
        logic [SW-1:0] er;
        wait_frame_start(ok);
        cap_done = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) acc_at[i] = 0;
        fork
            begin
                sample_l_i     = 24'h3C0000;
                sample_r_i     = 24'hC30000;
                sample_valid_i = 1'b1;
                for (int i = 0; i < 1200 && !cap_done; i++) begin
                    rdy = sample_ready_o;
                    @(negedge AMCLK_i);
                    if (rdy) begin
                        if (n < 8) acc_at[n] = i;
                        n++;
                        sample_l_i = 24'h3C0000 | SW'(n);
                        sample_r_i = 24'hC30000 | SW'(n);
                    end
                end
                sample_valid_i = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    capture_frame(data, ws, ur, ok);
                    el = 24'h3C0000 | SW'(f);
                    er = 24'hC30000 | SW'(f);
                    vec_cnt++; if (data !== frame_of(el, er)) begin err_cnt++; $display("FAIL b2b_data%0d: got %h expected %h", f, data, frame_of(el, er)); end
                    vec_cnt++; if (ur !== 1'b0) begin err_cnt++; $display("FAIL b2b_ur%0d: got %b expected 0", f, ur); end
                    $display("[b2b] frame %0d data %h", f, data);
                end
                cap_done = 1'b1;
            end
        join
        vec_cnt++; if (n != 4) begin err_cnt++; $display("FAIL b2b_accepts: got %0d expected 4", n); end
        vec_cnt++; if (acc_at[2] - acc_at[1] != FRAME_CYC) begin err_cnt++; $display("FAIL b2b_spacing1: got %0d expected %0d", acc_at[2] - acc_at[1], FRAME_CYC); end
        vec_cnt++; if (acc_at[3] - acc_at[2] != FRAME_CYC) begin err_cnt++; $display("FAIL b2b_spacing2: got %0d expected %0d", acc_at[3] - acc_at[2], FRAME_CYC); end
        $display("[b2b] %0d accepts", n);
    endtask

    // Valid raised in the load cycle with the holding register full.
    task automatic test_load_collision();
        bit          ok;
        logic [63:0] data;
        logic [63:0] ws;
        logic        ur;
        wait_frame_start(ok);
        push_pair(24'h123456, 24'hFEDCBA, ok);
        fork
            begin
                repeat (FRAME_CYC - 2) @(negedge AMCLK_i);
                sample_l_i     = 24'h0F0F0F;
                sample_r_i     = 24'hF0F0F0;
                sample_valid_i = 1'b1;
                vec_cnt++; if (sample_ready_o !== 1'b0) begin err_cnt++; $display("FAIL coll_ready_load: got %b expected 0", sample_ready_o); end
                @(negedge AMCLK_i);
                vec_cnt++; if (frame_start_o !== 1'b1) begin err_cnt++; $display("FAIL coll_fs: got %b expected 1", frame_start_o); end
                vec_cnt++; if (sample_ready_o !== 1'b1) begin err_cnt++; $display("FAIL coll_ready_next: got %b expected 1", sample_ready_o); end
                @(negedge AMCLK_i);
                vec_cnt++; if (sample_ready_o !== 1'b0) begin err_cnt++; $display("FAIL coll_ready_taken: got %b expected 0", sample_ready_o); end
                sample_valid_i = 1'b0;
            end
            begin
                capture_frame(data, ws, ur, ok);
                vec_cnt++; if (data !== frame_of(24'h123456, 24'hFEDCBA)) begin err_cnt++; $display("FAIL coll_first: got %h expected %h", data, frame_of(24'h123456, 24'hFEDCBA)); end
                $display("[collision] held frame %h", data);
                capture_frame(data, ws, ur, ok);
                vec_cnt++; if (data !== frame_of(24'h0F0F0F, 24'hF0F0F0)) begin err_cnt++; $display("FAIL coll_second: got %h expected %h", data, frame_of(24'h0F0F0F, 24'hF0F0F0)); end
                vec_cnt++; if (ur !== 1'b0) begin err_cnt++; $display("FAIL coll_second_ur: got %b expected 0", ur); end
                $display("[collision] late frame %h", data);
            end
        join
    endtask

    task automatic test_mid_reset();
        bit          ok;
        int          lat;
        logic        ur_seen;
        logic        d_seen;
        logic [63:0] data;
        logic [63:0] ws;
        logic        ur;
        wait_frame_start(ok);
        push_pair(24'h000000, 24'hFFFFFF, ok);
        wait_frame_start(ok);
        push_pair(24'hABCDEF, 24'h654321, ok);
        repeat (150) @(negedge AMCLK_i);
        vec_cnt++; if (ASDATA_o !== 1'b1) begin err_cnt++; $display("FAIL mrst_pre_data: got %b expected 1", ASDATA_o); end
        vec_cnt++; if (ALRCLK_o !== 1'b1) begin err_cnt++; $display("FAIL mrst_pre_ws: got %b expected 1", ALRCLK_o); end
        vec_cnt++; if (ASCLK_o !== 1'b1) begin err_cnt++; $display("FAIL mrst_pre_asclk: got %b expected 1", ASCLK_o); end
        nARST = 1'b0;
        #1;
        vec_cnt++; if (ASCLK_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_asclk: got %b expected 0", ASCLK_o); end
        vec_cnt++; if (ALRCLK_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_ws: got %b expected 0", ALRCLK_o); end
        vec_cnt++; if (ASDATA_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_data: got %b expected 0", ASDATA_o); end
        vec_cnt++; if (sample_ready_o !== 1'b1) begin err_cnt++; $display("FAIL mrst_ready: got %b expected 1", sample_ready_o); end
        vec_cnt++; if (frame_start_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_fs: got %b expected 0", frame_start_o); end
        vec_cnt++; if (underrun_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_ur: got %b expected 0", underrun_o); end
        repeat (3) @(negedge AMCLK_i);
        nARST = 1'b1;
        lat = 0;
        ur_seen = 1'b0;
        d_seen = 1'b1;
        for (int i = 1; i <= 16 && lat == 0; i++) begin
            @(negedge AMCLK_i);
            if (frame_start_o) begin
                lat = i;
                ur_seen = underrun_o;
                d_seen = ASDATA_o;
            end
        end
        vec_cnt++; if (lat != DIV) begin err_cnt++; $display("FAIL mrst_latency: got %0d expected %0d", lat, DIV); end
        vec_cnt++; if (ur_seen !== 1'b1) begin err_cnt++; $display("FAIL mrst_first_ur: got %b expected 1", ur_seen); end
        vec_cnt++; if (d_seen !== 1'b0) begin err_cnt++; $display("FAIL mrst_first_data: got %b expected 0", d_seen); end
        $display("[midreset] held pair dropped, underrun %b after %0d cycles", ur_seen, lat);
        nARST = 1'b0;
        repeat (2) @(negedge AMCLK_i);
        nARST = 1'b1;
        push_pair(24'hC00001, 24'h000003, ok);
        capture_frame(data, ws, ur, ok);
        vec_cnt++; if (ur !== 1'b0) begin err_cnt++; $display("FAIL mrst_push_ur: got %b expected 0", ur); end
        vec_cnt++; if (data !== frame_of(24'hC00001, 24'h000003)) begin err_cnt++; $display("FAIL mrst_push_data: got %h expected %h", data, frame_of(24'hC00001, 24'h000003)); end
        $display("[midreset] early push frame %h", data);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_pattern();
        test_full_scale();
        test_back_to_back();
        test_load_collision();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
